gpc_23_3: RTL and testbench
===========================

Name: gpc_23_3

Overview:
- Registered generalized parallel counter (GPC) of type (2,3;3).
- Counts three weight-1 input bits and two weight-2 input bits, and emits the 3-bit binary sum (range 0..7).
- Leaf compressor in multi-operand adder / multiplier partial-product reduction trees. Instances are chained column-wise by the tree generator.

Parameters:
- OUT_REG, default 1: 1 = output registered on clk (latency 1 cycle); 0 = purely combinational path, with clk/rst_n and the valid register unused.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies src0/src1 this cycle
- src0  input  3  bits of weight 1 (column i)
- src1  input  2  bits of weight 2 (column i+1)
- dst  output  3  binary sum: dst = popcount(src0) + 2*popcount(src1)
- out_valid  output  1  dst holds the result of a valid input

Behaviour:
- Arithmetic:
  - sum = src0[0] + src0[1] + src0[2] + 2*(src1[0] + src1[1]).
  - Maximum is 3 + 4 = 7, so 3 bits never overflow. No truncation and no saturation are needed.
- Reference structure:
  - Full adder on src0[2:0] gives s0 (weight 1) and c0 (weight 2).
  - Full adder on {c0, src1[1], src1[0]} gives s1 (weight 2) and c1 (weight 4).
  - dst = {c1, s1, s0}.
  - Any logic with an identical truth table (all 32 input combinations) is acceptable.
- OUT_REG=1:
  - Async reset (rst_n low, independent of clk): dst = 3'b000 and out_valid = 0, immediately; held while rst_n is low.
  - Each rising clk edge with rst_n high: out_valid <= in_valid.
  - dst <= sum when in_valid = 1; dst holds its previous value when in_valid = 0.
  - Latency exactly 1 cycle; throughput 1 result per cycle. No backpressure and no ready signal.
  - Reset asserted mid-stream discards any in-flight result. The first valid result after reset release appears the cycle after the first in_valid sample.
  - The bit order of src0 and of src1 is irrelevant (inputs are symmetric within a weight class).
- OUT_REG=0:
  - dst = sum combinationally; out_valid = in_valid combinationally.
  - No reset effect.
- X/unknown inputs while in_valid = 0 must not corrupt dst.

Test Plan:
- Exhaustive: all 32 {src1, src0} combinations with in_valid = 1, back-to-back -> each cycle dst equals popcount(src0) + 2*popcount(src1) of the previous cycle's inputs; out_valid = 1 throughout.
- Directed values:
  - src0=3'h5, src1=2'h1 -> dst = 4
  - src0=3'h6, src1=2'h3 -> dst = 6
  - src0=3'h7, src1=2'h3 -> dst = 7
  - src0=3'h4, src1=2'h0 -> dst = 1
  - src0=3'h0, src1=2'h0 -> dst = 0
- Reset: drive src0=3'h7, src1=2'h3, in_valid=1 for several cycles, then pull rst_n low between clock edges -> dst = 0 and out_valid = 0 immediately, without waiting for a clk edge; after release, results resume one cycle after the next valid input.
- Hold: after src0=3'h3, src1=2'h2 valid (dst = 4), drive in_valid = 0 with random src values -> dst stays 4 and out_valid = 0.
- OUT_REG=0 build: apply src0=3'h5, src1=2'h3 -> dst = 6 within the same delta cycle, with no clock required.

Source files
------------

// File: rtl/gpc_23_3_if.sv
// Operand/result bundle for the (2,3;3) parallel counter.
// master drives the column bits, slave returns the sum.
interface gpc_23_3_if;
    logic       in_valid;
    logic [2:0] src0;
    logic [1:0] src1;
    logic [2:0] dst;
    logic       out_valid;

    modport master (
        output in_valid,
        output src0,
        output src1,
        input  dst,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  src0,
        input  src1,
        output dst,
        output out_valid
    );
endinterface

// File: rtl/gpc_23_3.sv
// (2,3;3) generalized parallel counter: popcount(src0) + 2*popcount(src1).
// Optional output register; hold on idle so X on idle inputs is harmless.
module gpc_23_3 #(
    parameter int OUT_REG = 1
) (
    input logic        clk,
    input logic        rst_n,
    gpc_23_3_if.slave  bus
);

    logic       s0;
    logic       c0;
    logic       s1;
    logic       c1;
    logic [2:0] sum;

    // two cascaded full adders: weight-1 column, then weight-2 column
    always_comb begin
        s0  = bus.src0[0] ^ bus.src0[1] ^ bus.src0[2];
        c0  = (bus.src0[0] & bus.src0[1])
            | (bus.src0[0] & bus.src0[2])
            | (bus.src0[1] & bus.src0[2]);
        s1  = c0 ^ bus.src1[0] ^ bus.src1[1];
        c1  = (c0 & bus.src1[0])
            | (c0 & bus.src1[1])
            | (bus.src1[0] & bus.src1[1]);
        sum = {c1, s1, s0};
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [2:0] dst_q;
            logic       vld_q;

            // result register; updates only on valid, valid flag follows input
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dst_q <= 3'b000;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= bus.in_valid;
                    if (bus.in_valid) begin
                        dst_q <= sum;
                    end
                end
            end

            assign bus.dst       = dst_q;
            assign bus.out_valid = vld_q;
        end else begin : g_comb
            logic unused_clk_rst;

            assign unused_clk_rst = clk ^ rst_n;
            assign bus.dst        = sum;
            assign bus.out_valid  = bus.in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_gpc_23_3.sv
// Bench for gpc_23_3: registered and combinational builds
// against a popcount reference model.
module tb_gpc_23_3;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    logic [2:0] exp_dst;
    logic       exp_vld;

    gpc_23_3_if rif ();
    gpc_23_3_if cif ();

    gpc_23_3 #(.OUT_REG(1)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rif.slave)
    );

    gpc_23_3 #(.OUT_REG(0)) u_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_sum(input logic [2:0] a, input logic [1:0] b);
        return $countones(a) + 2 * $countones(b);
    endfunction

    // drive one cycle on the registered build, update model, check
    task automatic step(input logic v, input logic [2:0] a,
                        input logic [1:0] b, input string tag);
        rif.in_valid = v;
        rif.src0     = a;
        rif.src1     = b;
        @(posedge clk);
        #1;
        exp_vld = v;
        if (v)
            exp_dst = 3'(ref_sum(a, b));
        chk({tag, ".dst"}, int'(rif.dst), int'(exp_dst));
        chk({tag, ".vld"}, int'(rif.out_valid), int'(exp_vld));
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        exp_dst      = 3'd0;
        exp_vld      = 1'b0;
        rst_n        = 1'b0;
        rif.in_valid = 1'b0;
        rif.src0     = 3'd0;
        rif.src1     = 2'd0;
        cif.in_valid = 1'b0;
        cif.src0     = 3'd0;
        cif.src1     = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.dst", int'(rif.dst), 0);
        chk("rst.vld", int'(rif.out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            logic [4:0] c;
            c = 5'(i);
            step(1'b1, c[2:0], c[4:3], "exh");
        end

        step(1'b1, 3'h5, 2'h1, "d54");
        chk("d54.lit", int'(rif.dst), 4);
        step(1'b1, 3'h6, 2'h3, "d63");
        chk("d63.lit", int'(rif.dst), 6);
        step(1'b1, 3'h7, 2'h3, "d73");
        chk("d73.lit", int'(rif.dst), 7);
        step(1'b1, 3'h4, 2'h0, "d40");
        chk("d40.lit", int'(rif.dst), 1);
        step(1'b1, 3'h0, 2'h0, "d00");
        chk("d00.lit", int'(rif.dst), 0);

        step(1'b1, 3'h3, 2'h2, "hold0");
        chk("hold0.lit", int'(rif.dst), 4);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'($urandom), 2'($urandom), "hold");
            chk("hold.lit", int'(rif.dst), 4);
        end

        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom),
                 2'($urandom), "rnd");
        end

        for (int i = 0; i < 4; i++)
            step(1'b1, 3'h7, 2'h3, "pre");
        #3;
        rst_n = 1'b0;
        #1;
        exp_dst = 3'd0;
        exp_vld = 1'b0;
        chk("arst.dst", int'(rif.dst), 0);
        chk("arst.vld", int'(rif.out_valid), 0);
        @(posedge clk);
        #1;
        chk("arst.hold", int'(rif.dst), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 3'h7, 2'h3, "post0");
        step(1'b1, 3'h6, 2'h1, "post1");
        step(1'b1, 3'h1, 2'h2, "post2");

        cif.in_valid = 1'b1;
        cif.src0     = 3'h5;
        cif.src1     = 2'h3;
        #1;
        chk("comb.dst", int'(cif.dst), 6);
        chk("comb.vld", int'(cif.out_valid), 1);
        for (int i = 0; i < 40; i++) begin
            logic       v;
            logic [2:0] a;
            logic [1:0] b;
            v = 1'($urandom);
            a = 3'($urandom);
            b = 2'($urandom);
            cif.in_valid = v;
            cif.src0     = a;
            cif.src1     = b;
            #1;
            chk("comb.rdst", int'(cif.dst), ref_sum(a, b));
            chk("comb.rvld", int'(cif.out_valid), int'(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
